// File: rtl/calculator_if.sv
// calculator_if: operand/op-code/result bundle for the calculator datapath.
//   a, b         16-bit unsigned operands
//   op_code      2-bit operation select (00 add, 01 sub, 10 mul, 11 div)
//   result       16-bit registered result
//   overflow     registered overflow/borrow flag
//   div_by_zero  registered divide-by-zero flag
// Modports: master drives operands and reads results; slave is the calculator.
interface calculator_if;
   logic [15:0] a;
   logic [15:0] b;
   logic [1:0]  op_code;
   logic [15:0] result;
   logic        overflow;
   logic        div_by_zero;

   modport master (
      output a, b, op_code,
      input  result, overflow, div_by_zero
   );

   modport slave (
      input  a, b, op_code,
      output result, overflow, div_by_zero
   );
endinterface

// File: rtl/calculator.sv
// calculator: registered 16-bit unsigned four-function ALU (add, sub, mul, div).
// Operands and op code are sampled on every rising clk edge; result and flags are
// registered and recomputed each cycle (flags are not sticky).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset (result=0, flags=0), priority over compute
//   bus  calculator_if.slave: a, b, op_code in; result, overflow, div_by_zero out
// Build option: define CALC_SATURATE_EN to saturate results on overflow
// (add/mul -> 16'hFFFF, sub borrow -> 16'h0000); flags are unchanged.
module calculator (
   input  logic          clk,
   input  logic          rst,
   calculator_if.slave   bus
);

   logic [16:0] sum;
   logic [16:0] diff;
   logic [31:0] prod;
   logic [15:0] divisor;
   logic [15:0] quot;

   logic [15:0] result_d, result_q;
   logic        overflow_d, overflow_q;
   logic        div_by_zero_d, div_by_zero_q;

   always_comb begin
      sum     = {1'b0, bus.a} + {1'b0, bus.b};
      // Bit 16 of the 17-bit difference is the borrow, i.e. b > a.
      diff    = {1'b0, bus.a} - {1'b0, bus.b};
      prod    = 32'(bus.a) * 32'(bus.b);
      // Keep the divider free of a zero divisor; the b==0 case is overridden below.
      divisor = (bus.b == 16'd0) ? 16'd1 : bus.b;
      quot    = bus.a / divisor;
   end

   always_comb begin
      result_d      = 16'h0000;
      overflow_d    = 1'b0;
      div_by_zero_d = 1'b0;
      unique case (bus.op_code)
         2'b00: begin
            overflow_d = sum[16];
`ifdef CALC_SATURATE_EN
            result_d   = sum[16] ? 16'hFFFF : sum[15:0];
`else
            result_d   = sum[15:0];
`endif
         end
         2'b01: begin
            overflow_d = diff[16];
`ifdef CALC_SATURATE_EN
            result_d   = diff[16] ? 16'h0000 : diff[15:0];
`else
            result_d   = diff[15:0];
`endif
         end
         2'b10: begin
            overflow_d = (prod[31:16] != 16'd0);
`ifdef CALC_SATURATE_EN
            result_d   = overflow_d ? 16'hFFFF : prod[15:0];
`else
            result_d   = prod[15:0];
`endif
         end
         2'b11: begin
            if (bus.b == 16'd0) begin
               result_d      = 16'hFFFF;
               div_by_zero_d = 1'b1;
            end else begin
               result_d      = quot;
            end
         end
         default: begin
            result_d = 16'h0000;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q      <= 16'h0000;
         overflow_q    <= 1'b0;
         div_by_zero_q <= 1'b0;
      end else begin
         result_q      <= result_d;
         overflow_q    <= overflow_d;
         div_by_zero_q <= div_by_zero_d;
      end
   end

   assign bus.result      = result_q;
   assign bus.overflow    = overflow_q;
   assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_calculator.sv
// tb_calculator: self-checking bench for calculator. Directed vectors cover reset,
// the four ops, overflow/borrow, saturation (when CALC_SATURATE_EN is defined) and
// divide-by-zero; a random stream with occasional resets is checked against a
// plain-arithmetic reference model.
module tb_calculator;

`ifdef CALC_SATURATE_EN
   localparam bit Sat = 1'b1;
`else
   localparam bit Sat = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   calculator_if bus ();

   calculator dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  op;
      logic [15:0] r;
      logic        ov;
      logic        dz;
   } vec_t;

   // Reference model using wide integer arithmetic.
   function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [1:0] op, output logic [15:0] r,
                                 output logic ov, output logic dz);
      longint la;
      longint lb;
      longint t;
      la = longint'(a);
      lb = longint'(b);
      ov = 1'b0;
      dz = 1'b0;
      r  = 16'h0000;
      case (op)
         2'd0: begin
            t  = la + lb;
            ov = (t > 65535);
            r  = (ov && Sat) ? 16'hFFFF : 16'(t % 65536);
         end
         2'd1: begin
            ov = (lb > la);
            t  = (la - lb + 65536) % 65536;
            r  = (ov && Sat) ? 16'h0000 : 16'(t);
         end
         2'd2: begin
            t  = la * lb;
            ov = (t > 65535);
            r  = (ov && Sat) ? 16'hFFFF : 16'(t % 65536);
         end
         default: begin
            if (lb == 0) begin
               r  = 16'hFFFF;
               dz = 1'b1;
            end else begin
               r  = 16'(la / lb);
            end
         end
      endcase
   endfunction

   // Drive one vector, let one rising edge capture it, then sample 1 ns later.
   task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
      bus.a       = a;
      bus.b       = b;
      bus.op_code = op;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      apply(16'd7, 16'd3, 2'b00);
      checks++;
      if (bus.result !== 16'h0000) begin
         errors++;
         $display("FAIL reset_result got %h want 0000", bus.result);
      end
      checks++;
      if (bus.overflow !== 1'b0 || bus.div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got ov=%b dz=%b want 0 0", bus.overflow, bus.div_by_zero);
      end
      rst = 1'b0;
      apply(16'd7, 16'd3, 2'b00);
      checks++;
      if (bus.result !== 16'd10) begin
         errors++;
         $display("FAIL post_reset_add got %0d want 10", bus.result);
      end
   endtask

   task automatic test_basic_ops;
      logic [15:0] exp_r [4];
      exp_r = '{16'd15, 16'd5, 16'd50, 16'd2};
      for (int i = 0; i < 4; i++) begin
         apply(16'd10, 16'd5, 2'(i));
         checks++;
         if (bus.result !== exp_r[i] || bus.overflow !== 1'b0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL basic_op%0d got r=%0d ov=%b dz=%b want r=%0d ov=0 dz=0",
                     i, bus.result, bus.overflow, bus.div_by_zero, exp_r[i]);
         end
      end
   endtask

   task automatic test_boundaries;
      vec_t v [8];
      v = '{
         '{16'hFFFF, 16'd1,     2'd0, Sat ? 16'hFFFF : 16'h0000, 1'b1, 1'b0},
         '{16'd3,    16'd5,     2'd1, Sat ? 16'h0000 : 16'hFFFE, 1'b1, 1'b0},
         '{16'd5,    16'd5,     2'd1, 16'h0000,                  1'b0, 1'b0},
         '{16'h0100, 16'h0100,  2'd2, Sat ? 16'hFFFF : 16'h0000, 1'b1, 1'b0},
         '{16'd255,  16'd257,   2'd2, 16'd65535,                 1'b0, 1'b0},
         '{16'd1234, 16'd0,     2'd3, 16'hFFFF,                  1'b0, 1'b1},
         '{16'd1234, 16'd10,    2'd3, 16'd123,                   1'b0, 1'b0},
         '{16'd0,    16'd0,     2'd0, 16'h0000,                  1'b0, 1'b0}
      };
      for (int i = 0; i < 8; i++) begin
         apply(v[i].a, v[i].b, v[i].op);
         checks++;
         if (bus.result !== v[i].r || bus.overflow !== v[i].ov ||
             bus.div_by_zero !== v[i].dz) begin
            errors++;
            $display("FAIL boundary%0d got r=%h ov=%b dz=%b want r=%h ov=%b dz=%b",
                     i, bus.result, bus.overflow, bus.div_by_zero, v[i].r, v[i].ov, v[i].dz);
         end
      end
   endtask

   task automatic test_random_stream;
      logic [15:0] a, b, er;
      logic [1:0]  op;
      logic        eov, edz;
      for (int i = 0; i < 10000; i++) begin
         a  = 16'($urandom);
         b  = 16'($urandom);
         op = 2'($urandom);
         case ($urandom_range(0, 9))
            0: b = 16'd0;
            1: b = a;
            2: begin a = 16'($urandom_range(0, 300)); b = 16'($urandom_range(0, 300)); end
            default: ;
         endcase
         rst = ($urandom_range(0, 49) == 0);
         if (rst) begin
            er = 16'h0000; eov = 1'b0; edz = 1'b0;
         end else begin
            model(a, b, op, er, eov, edz);
         end
         apply(a, b, op);
         checks++;
         if (bus.result !== er || bus.overflow !== eov || bus.div_by_zero !== edz) begin
            errors++;
            $display("FAIL random%0d rst=%b a=%h b=%h op=%0d got r=%h ov=%b dz=%b want r=%h ov=%b dz=%b",
                     i, rst, a, b, op, bus.result, bus.overflow, bus.div_by_zero, er, eov, edz);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      bus.a       = 16'd0;
      bus.b       = 16'd0;
      bus.op_code = 2'd0;
      test_reset();
      test_basic_ops();
      test_boundaries();
      test_random_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
